// File: rtl/colpar_slice_writer.sv
// Write-side controller for the column-parity core: takes processed 25-bit slices over
// valid/ready, writes them in order to the slice memory and keeps an XOR checksum.
module colpar_slice_writer #(
    parameter int SLICE_W  = 25,
    parameter int N_SLICES = 64,
    parameter int ADDR_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [SLICE_W-1:0] in_slice,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [SLICE_W-1:0] mem_wdata,
    input  logic               mem_ack,
    output logic [SLICE_W-1:0] checksum,
    output logic               ready,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RECV  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SLICES - 1);

    state_t             state;
    logic [ADDR_W-1:0]  slice_cnt;
    logic [SLICE_W-1:0] capture;

    // Address and data come straight from the counter and capture register, so they
    // cannot move while a write is waiting for its acknowledge.
    assign mem_addr  = slice_cnt;
    assign mem_wdata = capture;

    // Moore flags are registered: each branch loads the flags of the state it enters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            slice_cnt <= '0;
            capture   <= '0;
            checksum  <= '0;
            ready     <= 1'b1;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
        end else begin
            ready    <= 1'b0;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ARM;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_ARM: begin
                    slice_cnt <= '0;
                    checksum  <= '0;
                    if (!start) begin
                        state    <= S_RECV;
                        in_ready <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (in_valid) begin
                        capture <= in_slice;
                        state   <= S_WRITE;
                        mem_we  <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        checksum <= checksum ^ capture;
                        if (slice_cnt == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            slice_cnt <= slice_cnt + ADDR_W'(1);
                            state     <= S_RECV;
                            in_ready  <= 1'b1;
                        end
                    end else begin
                        mem_we <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_colpar_slice_writer.sv
// Bench for colpar_slice_writer: a transaction-level model of the slice stream and
// memory image, checked every cycle, plus literal expectations for each scenario.
module tb_colpar_slice_writer;

    localparam int SLICE_W  = 25;
    localparam int N        = 64;
    localparam int ADDR_W   = 6;

    localparam int M_STALL  = 1;
    localparam int M_GAP    = 2;
    localparam int M_PULSE  = 4;
    localparam int M_RSTMID = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [SLICE_W-1:0] in_slice = '0;
    logic               mem_ack = 1'b0;
    logic               in_ready, mem_we, ready, done;
    logic [ADDR_W-1:0]  mem_addr;
    logic [SLICE_W-1:0] mem_wdata, checksum;

    colpar_slice_writer #(.SLICE_W(SLICE_W), .N_SLICES(N), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_slice(in_slice),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .checksum(checksum), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [SLICE_W-1:0] job_data [N];
    logic [SLICE_W-1:0] tb_mem [N];
    logic [SLICE_W-1:0] model_ck = '0;
    int  acc_cnt = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    bit  job_active = 0;
    bit  arming = 0;
    bit  exp_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Stream model: the n-th write must carry the n-th offered slice at address n.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ready", ready, 1);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_done", done, 0);
            chk("rst_checksum", checksum, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            model_ck   = '0;
            job_active = 0;
            exp_done   = 0;
            acc_cnt    = 0;
            wr_cnt     = 0;
        end else begin
            chk("done", done, exp_done);
            if (done) done_cnt++;
            if (exp_done) job_active = 0;
            exp_done = 0;
            if (!arming) chk("checksum", checksum, model_ck);
            if (!job_active) begin
                chk("idle_mem_we", mem_we, 0);
                chk("idle_in_ready", in_ready, 0);
            end else begin
                chk("ready_and_we", in_ready & mem_we, 0);
                if (in_ready && in_valid) acc_cnt++;
                if (mem_we) begin
                    if (wr_cnt >= N) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_write actual=addr %0d required=no write", mem_addr);
                    end else begin
                        chk("mem_addr", mem_addr, wr_cnt);
                        chk("mem_wdata", mem_wdata, job_data[wr_cnt]);
                        if (mem_ack) begin
                            tb_mem[wr_cnt] = mem_wdata;
                            model_ck = model_ck ^ job_data[wr_cnt];
                            if (wr_cnt == N - 1) exp_done = 1;
                            wr_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Returns the cycle (counting the one where start falls as cycle 1) in which done is seen.
    task automatic run_job(input int hold, input int mode, output int done_cycle);
        int edges;
        int stall_left;
        bit seen;
        stall_left = 5;
        seen = 0;
        done_cycle = 0;
        arming   = 1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_slice = job_data[0];
        mem_ack  = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        edges      = 1;
        model_ck   = '0;
        wr_cnt     = 0;
        acc_cnt    = 0;
        arming     = 0;
        job_active = 1;
        for (int c = 0; c < 2000; c++) begin
            if ((mode & M_RSTMID) != 0 && wr_cnt == 20) begin
                rst = 1'b0;
                seen = 1;
                break;
            end
            in_valid = ((mode & M_GAP) != 0) ? (c % 3 == 0) : 1'b1;
            in_slice = job_data[(acc_cnt < N) ? acc_cnt : N - 1];
            mem_ack  = 1'b1;
            if ((mode & M_STALL) != 0 && mem_we && mem_addr == 6'd10 && stall_left > 0) begin
                mem_ack = 1'b0;
                stall_left--;
            end
            start = ((mode & M_PULSE) != 0 && c == 40);
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                done_cycle = edges + 1;
                seen = 1;
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL job_timeout actual=no done required=done within 2000 cycles");
        end
        if ((mode & M_RSTMID) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    int cyc;
    int dc_before;

    initial begin
        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_done", done, 0);
        chk("reset_checksum", checksum, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full job without stalls: slices 1..64
        for (int k = 0; k < N; k++) job_data[k] = SLICE_W'(k + 1);
        run_job(1, 0, cyc);
        chk("full_done_cycle", cyc, 130);
        chk("full_checksum", checksum, 25'h40);
        chk("full_mem0", tb_mem[0], 1);
        chk("full_mem10", tb_mem[10], 11);
        chk("full_mem63", tb_mem[63], 64);
        chk("full_done_count", done_cnt, 1);
        chk("full_ready_after", ready, 1);

        // Five-cycle memory stall on slice 10
        run_job(1, M_STALL, cyc);
        chk("stall_done_cycle", cyc, 135);
        chk("stall_checksum", checksum, 25'h40);
        chk("stall_mem10", tb_mem[10], 11);
        chk("stall_done_count", done_cnt, 2);

        // Producer gaps with reversed data 64..1
        for (int k = 0; k < N; k++) job_data[k] = SLICE_W'(N - k);
        run_job(1, M_GAP, cyc);
        chk("gap_checksum", checksum, 25'h40);
        chk("gap_mem0", tb_mem[0], 64);
        chk("gap_mem63", tb_mem[63], 1);
        chk("gap_done_count", done_cnt, 3);

        // start held four cycles, then pulsed mid-job
        for (int k = 0; k < N; k++) job_data[k] = SLICE_W'(3 * k + 1);
        run_job(4, M_PULSE, cyc);
        chk("hold_done_cycle", cyc, 130);
        chk("hold_mem5", tb_mem[5], 16);
        chk("hold_done_count", done_cnt, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_no_restart", ready, 1);
        chk("hold_no_extra_done", done_cnt, 4);

        // Reset after 20 slices, then a clean job
        for (int k = 0; k < N; k++) job_data[k] = SLICE_W'(k * k + 7);
        dc_before = done_cnt;
        run_job(1, M_RSTMID, cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_checksum", checksum, 0);
        chk("rstmid_ready", ready, 1);
        rst = 1'b1;
        arming = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid_no_done", done_cnt, dc_before);
        for (int k = 0; k < N; k++) job_data[k] = SLICE_W'(k + 1);
        run_job(1, 0, cyc);
        chk("restart_done_cycle", cyc, 130);
        chk("restart_checksum", checksum, 25'h40);
        chk("restart_mem0", tb_mem[0], 1);
        chk("restart_done_count", done_cnt, dc_before + 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
